pipe_hazard_ctrl: RTL and testbench

//  Hazard/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB). It takes the decoded ID-stage

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/pipe_scoreboard.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flush sequencer.
//   REG_AW     register-address width (x0 is hardwired zero)
//   DEF_CNT_W  default performance-counter width
//   FWD_*      EX operand-select encodings
//   sb_entry_t per-stage scoreboard entry; SB_NOP is the bubble entry
package pipe_ctrl_pkg;

   localparam int unsigned REG_AW    = 5;
   localparam int unsigned DEF_CNT_W = 16;
   localparam int unsigned FWD_W     = 2;

   localparam logic [FWD_W-1:0] FWD_REG   = 2'b00;
   localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b01;
   localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b10;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              load;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
   } sb_entry_t;

   // All control bits zero: the NOP loaded on a bubble or a kill.
   localparam sb_entry_t SB_NOP = '0;

   // Entry produces a register result that a later instruction can depend on.
   function automatic logic writes_reg(input sb_entry_t e);
      return e.valid & e.regwrite & (e.rd != '0);
   endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Mirror of the EX/MEM/WB pipeline registers, shifting every clock.
//   clk, rst_n  clock, async active-low reset (clears all entries)
//   id_entry    fields of the instruction currently in ID
//   bubble_ex   load NOP into EX instead of the ID instruction
//   kill_mem    load NOP into MEM instead of the EX instruction
//   ex_entry, mem_entry, wb_entry  current stage contents
module pipe_scoreboard
   import pipe_ctrl_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  sb_entry_t id_entry,
   input  logic      bubble_ex,
   input  logic      kill_mem,
   output sb_entry_t ex_entry,
   output sb_entry_t mem_entry,
   output sb_entry_t wb_entry
);

   // Three-deep shift with per-stage NOP insertion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_entry  <= SB_NOP;
         mem_entry <= SB_NOP;
         wb_entry  <= SB_NOP;
      end else begin
         ex_entry  <= bubble_ex ? SB_NOP : id_entry;
         mem_entry <= kill_mem  ? SB_NOP : ex_entry;
         wb_entry  <= mem_entry;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/flush sequencer for a 5-stage IF/ID/EX/MEM/WB pipeline.
// Optional feature macro: FWD_EN (operand forwarding; stall only on load-use).
//   clk, rst_n                 clock, async active-low reset
//   id_valid, id_rs1, id_rs2   ID instruction and its source registers
//   id_use_rs1, id_use_rs2     ID instruction actually reads rs1/rs2
//   id_rd, id_regwrite, id_memtoreg  ID destination and WB controls
//   mem_br_taken               taken branch/jump resolved in MEM
//   stall_pc, stall_ifid       hold PC and IF/ID (combinational)
//   bubble_idex                load NOP into ID/EX (combinational)
//   flush_ifid, flush_exmem    kill IF/ID and the EX->MEM instruction (combinational)
//   fwd_a, fwd_b               EX operand selects: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall_cnt, flush_cnt       saturating stall-cycle / flush-event counters
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memtoreg,
   input  logic              mem_br_taken,
   output logic              stall_pc,
   output logic              stall_ifid,
   output logic              bubble_idex,
   output logic              flush_ifid,
   output logic              flush_exmem,
   output logic [FWD_W-1:0]  fwd_a,
   output logic [FWD_W-1:0]  fwd_b,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   sb_entry_t id_entry;
   sb_entry_t sb_ex;
   sb_entry_t sb_mem;
   sb_entry_t sb_wb;
   logic      br;
   logic      hz;
   logic      stall;
   logic      ex_hit;

   // Pack the ID-stage fields into a scoreboard entry.
   always_comb begin
      id_entry          = SB_NOP;
      id_entry.valid    = id_valid;
      id_entry.rd       = id_rd;
      id_entry.regwrite = id_regwrite;
      id_entry.load     = id_memtoreg;
      id_entry.rs1      = id_rs1;
      id_entry.rs2      = id_rs2;
   end

   pipe_scoreboard u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .id_entry  (id_entry),
      .bubble_ex (bubble_idex),
      .kill_mem  (br),
      .ex_entry  (sb_ex),
      .mem_entry (sb_mem),
      .wb_entry  (sb_wb)
   );

   // Gating with rst_n keeps every output low while reset is held.
   assign br = mem_br_taken & rst_n;

   assign ex_hit = writes_reg(sb_ex) &
                   ((id_use_rs1 & (id_rs1 == sb_ex.rd)) |
                    (id_use_rs2 & (id_rs2 == sb_ex.rd)));

`ifdef FWD_EN
   // With forwarding only a load still in EX is too late to bypass.
   assign hz = id_valid & ex_hit & sb_ex.load;

   // Youngest producer (MEM) wins over WB.
   function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                                 input sb_entry_t m,
                                                 input sb_entry_t w);
      if (writes_reg(m) && (m.rd == src)) return FWD_EXMEM;
      if (writes_reg(w) && (w.rd == src)) return FWD_MEMWB;
      return FWD_REG;
   endfunction

   // Operand selects for the instruction now in EX.
   always_comb begin
      fwd_a = FWD_REG;
      fwd_b = FWD_REG;
      if (sb_ex.valid) begin
         fwd_a = fwd_sel(sb_ex.rs1, sb_mem, sb_wb);
         fwd_b = fwd_sel(sb_ex.rs2, sb_mem, sb_wb);
      end
   end
`else
   logic mem_hit;

   // No bypass: any producer in EX or MEM blocks; WB is write-before-read.
   assign mem_hit = writes_reg(sb_mem) &
                    ((id_use_rs1 & (id_rs1 == sb_mem.rd)) |
                     (id_use_rs2 & (id_rs2 == sb_mem.rd)));
   assign hz      = id_valid & (ex_hit | mem_hit);
   assign fwd_a   = FWD_REG;
   assign fwd_b   = FWD_REG;
`endif

   // Not every scoreboard field feeds logic in every build.
   logic unused_sb;
   assign unused_sb = ^{sb_ex, sb_mem, sb_wb};

   // Flush has priority over stall.
   assign stall       = hz & ~br;
   assign stall_pc    = stall;
   assign stall_ifid  = stall;
   assign bubble_idex = hz | br;
   assign flush_ifid  = br;
   assign flush_exmem = br;

   // Saturating performance counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (br && (flush_cnt != '1))    flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (either FWD_EN build).
// Reference model: a queue of in-flight instructions tagged with their age
// past ID (0=EX, 1=MEM, 2=WB); hazards and forwarding are derived from it.
module tb_pipe_hazard_ctrl;

   localparam int unsigned TB_CNT_W   = 12;
   localparam int          SAT_MAX    = (1 << TB_CNT_W) - 1;
   localparam int          SAT_TARGET = (1 << TB_CNT_W) + 3;
`ifdef FWD_EN
   localparam int          LU_STALLS  = 1;
   localparam logic [1:0]  ADD_FWD    = 2'b01;
   localparam logic [1:0]  LU_FWD     = 2'b10;
`else
   localparam int          LU_STALLS  = 2;
   localparam logic [1:0]  ADD_FWD    = 2'b00;
   localparam logic [1:0]  LU_FWD     = 2'b00;
`endif

   typedef struct { bit v; int rs1; int rs2; bit u1; bit u2; int rd; bit rw; bit ld; } ins_t;
   typedef struct { int rd; int rs1; int rs2; bit rw; bit ld; int age; } fl_t;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memtoreg;
   logic [4:0]          id_rs1, id_rs2, id_rd;
   logic                mem_br_taken;
   logic                stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_exmem;
   logic [1:0]          fwd_a, fwd_b;
   logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;

   int  n_cmp = 0;
   int  n_bad = 0;
   fl_t inflight[$];
   int  m_stall_cnt, m_flush_cnt, m_stall_raw;
   bit  last_stall;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.CNT_W(TB_CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .mem_br_taken(mem_br_taken),
      .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
      .flush_ifid(flush_ifid), .flush_exmem(flush_exmem), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic ins_t mk(input int rd, input int rs1, input int rs2,
                               input bit u1, input bit u2, input bit rw, input bit ld);
      ins_t i;
      i.v = 1'b1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
      i.u1 = u1; i.u2 = u2; i.rw = rw; i.ld = ld;
      return i;
   endfunction

   function automatic ins_t nop();
      ins_t i;
      i = mk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      i.v = 1'b0;
      return i;
   endfunction

   task automatic drive(input ins_t i, input bit br);
      id_valid     = i.v;
      id_rs1       = 5'(i.rs1);
      id_rs2       = 5'(i.rs2);
      id_use_rs1   = i.u1;
      id_use_rs2   = i.u2;
      id_rd        = 5'(i.rd);
      id_regwrite  = i.rw;
      id_memtoreg  = i.ld;
      mem_br_taken = br;
   endtask

   // Does the ID instruction depend on a producer it cannot yet get its value from?
   function automatic bit model_hz(input ins_t i);
      bit hz = 1'b0;
      if (!i.v) return 1'b0;
      foreach (inflight[k]) begin
         bit dep;
         dep = inflight[k].rw && (inflight[k].rd != 0) &&
               ((i.u1 && (i.rs1 == inflight[k].rd)) || (i.u2 && (i.rs2 == inflight[k].rd)));
`ifdef FWD_EN
         if (dep && (inflight[k].age == 0) && inflight[k].ld) hz = 1'b1;
`else
         if (dep && (inflight[k].age <= 1)) hz = 1'b1;
`endif
      end
      return hz;
   endfunction

   // Source for one EX operand: nearest older producer wins.
   function automatic logic [1:0] src_sel(input int src);
      logic [1:0] sel = 2'b00;
      for (int age = 2; age >= 1; age--)
         foreach (inflight[k])
            if ((inflight[k].age == age) && inflight[k].rw && (inflight[k].rd != 0) &&
                (inflight[k].rd == src))
               sel = (age == 1) ? 2'b01 : 2'b10;
`ifndef FWD_EN
      sel = 2'b00;
`endif
      return sel;
   endfunction

   task automatic model_fwd(output logic [1:0] fa, output logic [1:0] fb);
      fa = 2'b00;
      fb = 2'b00;
      foreach (inflight[k])
         if (inflight[k].age == 0) begin
            fa = src_sel(inflight[k].rs1);
            fb = src_sel(inflight[k].rs2);
         end
   endtask

   function automatic void model_advance(input bit hz, input bit br, input ins_t i);
      fl_t nq[$];
      foreach (inflight[k]) begin
         fl_t e = inflight[k];
         if (br && (e.age == 0)) continue;
         e.age++;
         if (e.age <= 2) nq.push_back(e);
      end
      if (!br && !hz && i.v)
         nq.push_back('{rd: i.rd, rs1: i.rs1, rs2: i.rs2, rw: i.rw, ld: i.ld, age: 0});
      inflight = nq;
      if (hz && !br) begin
         m_stall_raw++;
         if (m_stall_cnt < SAT_MAX) m_stall_cnt++;
      end
      if (br && (m_flush_cnt < SAT_MAX)) m_flush_cnt++;
   endfunction

   // One pipeline cycle: present ID, check outputs against the model, then advance it.
   task automatic step(input ins_t i, input bit br);
      bit         hz;
      logic [1:0] fa, fb;
      logic [4:0] ctl;
      @(negedge clk);
      drive(i, br);
      #1;
      hz = model_hz(i);
      model_fwd(fa, fb);
      ctl = {hz & !br, hz & !br, hz | br, br, br};
      chk("ctl", 32'({stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_exmem}), 32'(ctl));
      chk("fwd", 32'({fwd_a, fwd_b}), 32'({fa, fb}));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
      chk("flush_cnt", 32'(flush_cnt), 32'(m_flush_cnt));
      model_advance(hz, br, i);
      last_stall = hz & !br;
   endtask

   // Re-present the same instruction while it is held in ID.
   task automatic run_ins(input ins_t i);
      int n = 0;
      step(i, 1'b0);
      while (last_stall) begin
         n++;
         if (n > 4) begin
            chk("stall_bound", 32'(n), 32'(4));
            return;
         end
         step(i, 1'b0);
      end
   endtask

   // Assert reset now (possibly mid-stall), check outputs, release on a falling edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_ctl", 32'({stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_exmem}), 32'(0));
      chk("rst_fwd", 32'({fwd_a, fwd_b}), 32'(0));
      chk("rst_cnt", 32'({stall_cnt, flush_cnt}), 32'(0));
      drive(nop(), 1'b0);
      inflight.delete();
      m_stall_cnt = 0;
      m_flush_cnt = 0;
      m_stall_raw = 0;
      last_stall  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      ins_t cur;
      int   k;
      drive(nop(), 1'b0);
      do_reset();

      // add x3,x1,x2 ; add x4,x3,x3
      run_ins(mk(3, 1, 2, 1, 1, 1, 0));
      run_ins(mk(4, 3, 3, 1, 1, 1, 0));
      step(nop(), 1'b0);
      chk("add_fwd_a", 32'(fwd_a), 32'(ADD_FWD));
      chk("add_fwd_b", 32'(fwd_b), 32'(ADD_FWD));

      // lw x5,0(x1) ; add x6,x5,x0
      do_reset();
      run_ins(mk(5, 1, 0, 1, 0, 1, 1));
      run_ins(mk(6, 5, 0, 1, 1, 1, 0));
      step(nop(), 1'b0);
      chk("lu_fwd_a", 32'(fwd_a), 32'(LU_FWD));
      chk("lu_fwd_b", 32'(fwd_b), 32'(0));
      chk("lu_stall_cnt", 32'(stall_cnt), 32'(LU_STALLS));

      // addi x0,x0,1 ; add x7,x0,x0
      do_reset();
      step(mk(0, 0, 0, 1, 0, 1, 0), 1'b0);
      step(mk(7, 0, 0, 1, 1, 1, 0), 1'b0);
      chk("x0_stall", 32'(stall_pc), 32'(0));
      step(nop(), 1'b0);
      chk("x0_fwd", 32'({fwd_a, fwd_b}), 32'(0));

      // Load-use hazard with a taken branch in the same cycle
      do_reset();
      step(mk(3, 1, 0, 1, 0, 1, 1), 1'b0);
      step(mk(4, 3, 3, 1, 1, 1, 0), 1'b1);
      chk("br_stall_pc", 32'(stall_pc), 32'(0));
      chk("br_flush", 32'({flush_ifid, flush_exmem, bubble_idex}), 32'(3'b111));
      step(mk(4, 3, 3, 1, 1, 1, 0), 1'b0);
      chk("br_killed_ex", 32'(stall_pc), 32'(0));
      chk("br_flush_cnt", 32'(flush_cnt), 32'(1));

      // Reset in the middle of a stall
      do_reset();
      step(mk(5, 1, 0, 1, 0, 1, 1), 1'b0);
      step(mk(6, 5, 5, 1, 1, 1, 0), 1'b0);
      chk("mid_stall_pre", 32'(stall_pc), 32'(1));
      do_reset();
      step(mk(9, 1, 2, 1, 1, 1, 0), 1'b0);
      chk("post_rst_issue", 32'(stall_pc), 32'(0));

      // Randomized traffic on a small register set to provoke frequent hazards
      do_reset();
      cur = nop();
      for (int c = 0; c < 2000; c++) begin
         if (!last_stall) begin
            cur = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                     bit'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                     $urandom_range(0, 4) < 2);
            cur.v = $urandom_range(0, 9) != 0;
         end
         step(cur, $urandom_range(0, 9) == 0);
      end

      // Dependent load chain until the stall counter must have saturated
      do_reset();
      k = 0;
      while ((m_stall_raw < SAT_TARGET) && (k < 20000)) begin
         run_ins(mk(1 + k % 2, 1 + (k + 1) % 2, 0, 1, 0, 1, 1));
         k++;
      end
      step(nop(), 1'b0);
      chk("sat_reached", 32'(m_stall_raw >= SAT_TARGET), 32'(1));
      chk("stall_sat", 32'(stall_cnt), 32'(SAT_MAX));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
